// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus responder.
package dbus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef enum logic [1:0] {RGN_RAM, RGN_MMIO, RGN_NONE} rgn_t;

    localparam logic [3:0] MMIO_LED   = 4'h0;
    localparam logic [3:0] MMIO_CYCLE = 4'h4;
    localparam logic [3:0] MMIO_SW    = 4'h8;

endpackage

// File: rtl/dbus_ram.sv
// Single-port DEPTHx32 word RAM with per-byte write enable and registered read.
module dbus_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (en) q <= mem[idx];
    end

endmodule

// File: rtl/dbus_responder.sv
// Handshaked responder for the CPU data bus: word RAM plus a 16-byte MMIO
// window (LED, free-running cycle counter, synchronized switches).
import dbus_pkg::*;

module dbus_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  wa,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    state_t          state;
    rgn_t            rgn_in, rgn_q;
    logic [31:0]     woff;
    logic [AW-1:0]   idx_q;
    logic [3:0]      off_q, wa_q;
    logic [31:0]     wdata_q;
    logic            mis_q;
    logic [15:0]     led, sw_meta, sw_sync;
    logic [31:0]     cycle;

    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AW-1:0]   ram_idx;
    logic [31:0]     ram_q;

    logic [31:0]     acc_rdata;
    logic            acc_err;
    logic [1:0]      led_wr;

    // Word offset from RAM_BASE; bit 31 is the borrow, set when addr < RAM_BASE.
    assign woff = {1'b0, addr[31:2]} - {1'b0, RAM_BASE[31:2]};

    always_comb begin
        rgn_in = RGN_NONE;
        if (!woff[31] && woff[30:0] < DEPTH_W)
            rgn_in = RGN_RAM;
        else if (addr[31:4] == MMIO_BASE[31:4])
            rgn_in = RGN_MMIO;
    end

    // Read is launched in IDLE off the live address so the word is ready in
    // ACCESS; the write lands at the ACCESS->RESP edge unless reset is asserted.
    assign ram_en  = (state == IDLE) && req;
    assign ram_idx = (state == IDLE) ? woff[AW-1:0] : idx_q;
    assign ram_we  = (state == ACCESS && rst && rgn_q == RGN_RAM && !mis_q) ? wa_q : 4'b0000;

    dbus_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .q     (ram_q)
    );

    always_comb begin
        acc_rdata = 32'h0;
        acc_err   = 1'b0;
        led_wr    = 2'b00;
        if (mis_q) begin
            acc_err = 1'b1;
        end else begin
            case (rgn_q)
                RGN_RAM: begin
                    if (wa_q == 4'b0000) acc_rdata = ram_q;
                end
                RGN_MMIO: begin
                    case (off_q)
                        MMIO_LED: begin
                            if (wa_q != 4'b0000) led_wr = wa_q[1:0];
                            else acc_rdata = {16'h0, led};
                        end
                        MMIO_CYCLE: begin
                            if (wa_q != 4'b0000) acc_err = 1'b1;
                            else acc_rdata = cycle;
                        end
                        MMIO_SW: begin
                            if (wa_q != 4'b0000) acc_err = 1'b1;
                            else acc_rdata = {16'h0, sw_sync};
                        end
                        default: acc_err = 1'b1;
                    endcase
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'h0;
            led   <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (req) begin
                        idx_q   <= woff[AW-1:0];
                        off_q   <= addr[3:0];
                        wa_q    <= wa;
                        wdata_q <= wdata;
                        mis_q   <= |addr[1:0];
                        rgn_q   <= rgn_in;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata <= acc_rdata;
                    err   <= acc_err;
                    if (led_wr[0]) led[7:0]  <= wdata_q[7:0];
                    if (led_wr[1]) led[15:8] <= wdata_q[15:8];
                    state <= RESP;
                end
                RESP: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cycle <= 32'h0;
        else      cycle <= cycle + 32'h1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta <= 16'h0;
            sw_sync <= 16'h0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    assign led_out = led;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed self-checking bench for dbus_responder.
module tb_dbus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  wa = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [15:0] sw_in = 16'h0;
    logic [15:0] led_out;

    int total = 0;
    int bad = 0;

    dbus_responder dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wa      (wa),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .sw_in   (sw_in),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    // One transaction: lat is the number of rising edges until ready (99 on timeout).
    task automatic bus(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req = 1'b1; wa = w; addr = a; wdata = d;
        lat = 99; rd = 32'hxxxx_xxxx; e = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i; rd = rdata; e = err;
                break;
            end
        end
        req = 1'b0; wa = 4'h0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        total++; if (led_out !== 16'h0) begin bad++; $display("FAIL reset_led got=%h want=0", led_out); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_ram;
        logic [31:0] rd; logic e; int lat;
        bus(4'hF, 32'h10, 32'hDEADBEEF, rd, e, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL ram_store_lat got=%0d want=3", lat); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ram_store_err got=%b want=0", e); end
        bus(4'h0, 32'h10, 32'h0, rd, e, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL ram_load_lat got=%0d want=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_load_data got=%h want=deadbeef", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ram_load_err got=%b want=0", e); end
    endtask

    task automatic test_byte_merge;
        logic [31:0] rd; logic e; int lat;
        bus(4'b0101, 32'h10, 32'h11223344, rd, e, lat);
        bus(4'h0, 32'h10, 32'h0, rd, e, lat);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL byte_merge got=%h want=de22be44", rd); end
    endtask

    task automatic test_mmio;
        logic [31:0] rd, c0, c1; logic e; int lat;
        bus(4'b0011, 32'hFFFF_0000, 32'h0000A5C3, rd, e, lat);
        total++; if (led_out !== 16'hA5C3) begin bad++; $display("FAIL led_write got=%h want=a5c3", led_out); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL led_write_err got=%b want=0", e); end
        bus(4'b1100, 32'hFFFF_0000, 32'hFFFF_FFFF, rd, e, lat);
        total++; if (led_out !== 16'hA5C3) begin bad++; $display("FAIL led_upper_ignored got=%h want=a5c3", led_out); end
        bus(4'h0, 32'hFFFF_0000, 32'h0, rd, e, lat);
        total++; if (rd !== 32'h0000A5C3) begin bad++; $display("FAIL led_read got=%h want=0000a5c3", rd); end
        bus(4'h0, 32'hFFFF_0004, 32'h0, c0, e, lat);
        bus(4'h0, 32'hFFFF_0004, 32'h0, c1, e, lat);
        total++; if (c1 - c0 !== 32'd3) begin bad++; $display("FAIL cycle_delta got=%0d want=3", c1 - c0); end
        sw_in = 16'h00F0;
        repeat (4) @(posedge clk);
        bus(4'h0, 32'hFFFF_0008, 32'h0, rd, e, lat);
        total++; if (rd !== 32'h000000F0) begin bad++; $display("FAIL sw_read got=%h want=000000f0", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL sw_read_err got=%b want=0", e); end
        bus(4'h0, 32'hFFFF_000C, 32'h0, rd, e, lat);
        total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL reserved_read got=%b/%h want=1/0", e, rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic e; int lat;
        bus(4'hF, 32'h12, 32'hFFFF_FFFF, rd, e, lat);
        total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL misaligned got=%b/%h want=1/0", e, rd); end
        bus(4'h0, 32'h10, 32'h0, rd, e, lat);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL misaligned_no_effect got=%h want=de22be44", rd); end
        bus(4'h0, 32'h1000, 32'h0, rd, e, lat);
        total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL out_of_range got=%b/%h want=1/0", e, rd); end
        bus(4'hF, 32'hFFFF_0004, 32'h1234_5678, rd, e, lat);
        total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL cycle_write got=%b/%h want=1/0", e, rd); end
        bus(4'h3, 32'hFFFF_0008, 32'h1234_5678, rd, e, lat);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL sw_write got=%b want=1", e); end
        total++; if (led_out !== 16'hA5C3) begin bad++; $display("FAIL led_after_errors got=%h want=a5c3", led_out); end
    endtask

    task automatic abort_op(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, output int seen);
        @(negedge clk);
        req = 1'b1; wa = w; addr = a; wdata = d;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0; wa = 4'h0;
        seen = int'(ready);
        repeat (4) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] rd; logic e; int lat, seen;
        abort_op(4'b0011, 32'hFFFF_0000, 32'h0000_1234, seen);
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_led_ready got=%0d want=0", seen); end
        total++; if (led_out !== 16'h0) begin bad++; $display("FAIL abort_led_value got=%h want=0", led_out); end
        bus(4'h0, 32'hFFFF_0004, 32'h0, rd, e, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL abort_next_lat got=%0d want=3", lat); end
        total++; if (rd >= 32'd16) begin bad++; $display("FAIL abort_cycle_small got=%0d want<16", rd); end
        abort_op(4'hF, 32'h10, 32'h0, seen);
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_ram_ready got=%0d want=0", seen); end
        bus(4'h0, 32'h10, 32'h0, rd, e, lat);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL abort_ram_kept got=%h want=de22be44", rd); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int pos [4];
        @(negedge clk);
        req = 1'b1; wa = 4'h0; addr = 32'h10; wdata = 32'h0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                if (n < 4) pos[n] = i;
                n++;
                total++; if (rdata !== 32'hDE22BE44) begin bad++; $display("FAIL b2b_data got=%h want=de22be44", rdata); end
                if (n == 4) req = 1'b0;
            end
        end
        req = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", n); end
        for (int k = 0; k < 4 && k < n; k++) begin
            total++; if (pos[k] !== 3 * (k + 1)) begin bad++; $display("FAIL b2b_spacing k=%0d got=%0d want=%0d", k, pos[k], 3 * (k + 1)); end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_byte_merge();
        test_mmio();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Responder end of the CPU data bus. It accepts load/store requests carrying a 4-bit byte write enable `wa`, a 32-bit address and 32-bit write data. It serves them from an internal word RAM or from a small memory-mapped I/O window (LED register, cycle counter, switch input), and answers with a one-cycle `ready` pulse. It sits between the `mips` core's data port and the board pins, as the handshaked replacement for the bare data memory.

## Interface
Parameters:
- `DEPTH`, default 1024: RAM size in 32-bit words; a power of two.
- `RAM_BASE`, default 32'h0000_0000: byte address of RAM word 0.
- `MMIO_BASE`, default 32'hFFFF_0000: byte address of the MMIO window, which is 16 bytes.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: reset; synchronous and active-low.
- `req`, in, 1: request valid; held until `ready`.
- `wa`, in, 4: byte write enables. `wa[i]` covers `wdata[8i+7:8i]`. 4'b0000 means a read.
- `addr`, in, 32: byte address; stable while `req` is high.
- `wdata`, in, 32: store data; stable while `req` is high.
- `rdata`, out, 32: load data; valid only while `ready` is high.
- `ready`, out, 1: one-cycle completion pulse.
- `err`, out, 1: error flag; qualified by `ready`.
- `sw_in`, in, 16: switch inputs; asynchronous.
- `led_out`, out, 16: LED register value.

## Operation
State machine:
- States are IDLE, ACCESS and RESP.
- IDLE: when `req`=1, latch `addr`, `wa` and `wdata`, decode the address, and go to ACCESS.
- ACCESS: perform the RAM or MMIO read/write, register `rdata`/`err`, and go to RESP.
- RESP: drive `ready`=1 and go to IDLE unconditionally.
- `req` sampled in RESP is not a new request. A back-to-back request is accepted in the IDLE cycle that follows.

Address decode, applied to the latched address:
- Misaligned access (`addr[1:0]`≠0): `err`=1, no side effect, `rdata`=0.
- RAM hit when RAM_BASE ≤ addr < RAM_BASE+4·DEPTH. Word index is `(addr-RAM_BASE)>>2`.
  - Write: bytes with `wa[i]`=1 are updated; other bytes keep their value.
  - Read: returns the full word.
- MMIO window, by offset from MMIO_BASE:
  - 0x0, LED: R/W. `wa[0]`/`wa[1]` write the low/high byte of the 16-bit register; `wa[3:2]` are ignored. Reads return {16'h0, led}.
  - 0x4, CYCLE: read-only 32-bit free-running counter, incremented every cycle, wrapping 32'hFFFF_FFFF→0. A read returns the value sampled in ACCESS. A write sets `err`=1 and changes nothing.
  - 0x8, SW: read-only {16'h0, sw_sync}. A write sets `err`=1.
  - 0xC: reserved. Reads return 0 with `err`=1; writes set `err`=1.
- Any other address: `err`=1, `rdata`=0, no side effect.
- `sw_in` passes through a 2-flop synchronizer before it is visible.
- `led_out` is driven directly from the LED register.

## Timing
- Reset with `rst`=0 at a rising edge:
  - State → IDLE; `ready`=0; `err`=0; `rdata`=0; LED=0; CYCLE=0; synchronizer flops=0.
  - RAM contents are not cleared.
- Reset mid-transaction (ACCESS or RESP) aborts with no `ready`. A write aborted in IDLE→ACCESS has not yet modified RAM.
- Latency: `req` seen in IDLE at edge N gives `ready` high during the cycle after edge N+2, i.e. 3 cycles per transaction. Maximum throughput is one access per 3 cycles.
- Outputs are registered: `rdata`, `err` and `ready` change only on clock edges.
- Write side effects (RAM, LED) take place at the ACCESS→RESP edge. A read issued right after a write returns the new value.
- `req` dropped before `ready` is a protocol violation. Behaviour is undefined but must not hang; the FSM always returns to IDLE.

## Structure
- Shared package `dbus_pkg`:
  - state enum {IDLE, ACCESS, RESP}
  - MMIO offset constants `MMIO_LED`=4'h0, `MMIO_CYCLE`=4'h4, `MMIO_SW`=4'h8
  - region decode enum {RGN_RAM, RGN_MMIO, RGN_NONE}
- Sub-module `dbus_ram`: synchronous single-port RAM, DEPTH×32, with a per-byte write enable and a registered read. It is instantiated once. The FSM, decode and MMIO registers stay in `dbus_responder`.

## Test plan
- Reset, then a RAM store at addr 0x10 with `wa`=4'hF, `wdata`=32'hDEADBEEF, then a load from 0x10 → `ready` 3 cycles after each `req`; load `rdata`=32'hDEADBEEF, `err`=0.
- Byte-enable merge: store 0x10 with `wa`=4'b0101, `wdata`=32'h11223344 over DEADBEEF, then load → `rdata`=32'hDE22BE44.
- MMIO: write LED with `wa`=4'b0011, `wdata`=32'h0000A5C3 → `led_out`=16'hA5C3. Two successive CYCLE reads differ by exactly 3. With `sw_in`=16'h00F0 held ≥3 cycles, an SW read → 32'h000000F0.
- Errors → `err`=1 with `ready`, `rdata`=0, memory/LED unchanged:
  - misaligned addr 0x12 (store);
  - addr 4·DEPTH (load);
  - write to CYCLE.
- Reset mid-op: assert `rst`=0 during ACCESS of a store → no `ready`, `led_out`=0, CYCLE reads small after release, FSM accepts the next `req` normally.
- Back-to-back: `req` held high across 4 consecutive loads → exactly 4 `ready` pulses, spaced 3 cycles apart.
